// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the bamse UART receiver port.
package uart_pkg;

    localparam int unsigned CPB_W              = 12;
    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned BIT_IDX_W          = $clog2(DATA_BITS);
    localparam int unsigned CLK_PER_BIT_MIN    = 4;
    localparam int unsigned UART_RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous circular FIFO with registered full/empty flags; head word is read combinationally.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_wr;
    logic             w_do_rd;

    // A write into a full FIFO is allowed only when the head leaves in the same cycle.
    assign w_do_rd = i_rd && !r_empty;
    assign w_do_wr = i_wr && (!r_full || w_do_rd);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_wr && !w_do_rd) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_do_rd && !w_do_wr) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver for the PicoBlaze port space with sticky framing/overrun flags.
// Define UART_RX_FIFO_EN to buffer bytes in a FIFO instead of a single holding register.
module uart_rx_port
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] i_Clk_per_bit,
    input  logic        i_RX_Serial,
    input  logic        i_rd,
    input  logic        i_clr_err,
    output logic [7:0]  o_RX_Byte,
    output logic        o_data_avail,
    output logic        o_RX_DV,
    output logic        o_RX_Active,
    output logic        o_frame_err,
    output logic        o_overrun
);

    rx_state_e            r_state;
    rx_state_e            w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CPB_W-1:0]     r_cnt;
    logic [CPB_W-1:0]     w_cnt_nxt;
    logic [CPB_W-1:0]     r_n;
    logic [CPB_W-1:0]     w_n_nxt;
    logic [CPB_W-1:0]     w_n_m1;
    logic [CPB_W-1:0]     w_half_m1;
    logic [BIT_IDX_W-1:0] r_bit;
    logic [BIT_IDX_W-1:0] w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_push;
    logic                 w_frame_set;
    logic                 w_accept;
    logic                 w_ovr_set;
    logic                 r_dv;
    logic                 r_active;
    logic                 r_frame_err;
    logic                 r_overrun;

    assign w_n_m1    = r_n - CPB_W'(1);
    assign w_half_m1 = (r_n >> 1) - CPB_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_RX_Serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_n      <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_n      <= w_n_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_active <= (w_state_nxt != ST_IDLE);
        end
    end

    // Bit timing: start bit checked at mid-bit, data/stop sampled one full bit period apart.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CPB_W'(1);
        w_n_nxt     = r_n;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_sync2) begin
                    w_n_nxt     = (i_Clk_per_bit < CPB_W'(CLK_PER_BIT_MIN)) ?
                                  CPB_W'(CLK_PER_BIT_MIN) : i_Clk_per_bit;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == w_half_m1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == w_n_m1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + BIT_IDX_W'(1);
                    if (r_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == w_n_m1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (r_sync2) begin
                        w_push = 1'b1;
                    end else begin
                        w_frame_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic [7:0] w_head;

    assign w_pop     = i_rd && !w_empty;
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .DEPTH (UART_RX_FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_accept),
        .i_wdata (r_shift),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_RX_Byte    = w_head;
    assign o_data_avail = !w_empty;
`else
    logic [7:0] r_hold;
    logic       r_avail;

    // A read in the same cycle frees the register, so the new byte replaces the old one.
    assign w_accept  = w_push && (!r_avail || i_rd);
    assign w_ovr_set = w_push && r_avail && !i_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_avail <= 1'b0;
        end else if (w_accept) begin
            r_hold  <= r_shift;
            r_avail <= 1'b1;
        end else if (i_rd) begin
            r_avail <= 1'b0;
        end
    end

    assign o_RX_Byte    = r_hold;
    assign o_data_avail = r_avail;
`endif

    // Sticky flags: a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv        <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_dv <= w_accept;
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_RX_DV     = r_dv;
    assign o_RX_Active = r_active;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
